// File: rtl/acs_322_pkg.sv
// Shared trellis constants and helpers for the (3,2,2) Viterbi ACS stage.
package vit322_pkg;

    localparam int unsigned N_STATES    = 8;
    localparam int unsigned N_BR        = 4;
    localparam int unsigned N_HD        = N_STATES * N_BR;
    localparam int unsigned SW          = 3;
    localparam int unsigned JW          = 2;
    localparam int unsigned HDW         = 2;
    localparam int unsigned DECW        = N_STATES * JW;
    localparam int unsigned PMW_DEFAULT = 6;
    localparam int unsigned PM_INIT     = 2 ** (PMW_DEFAULT - 2);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } acs_state_e;

    // Predecessor of state s on branch j: new input pair shifts in at the top.
    function automatic logic [SW-1:0] pred(input logic [SW-1:0] s, input logic [JW-1:0] j);
        return {s[0], j};
    endfunction

    // Position of HD(4s+j+1) in the zero-based branch-metric vector.
    function automatic logic [4:0] hd_idx(input logic [SW-1:0] s, input logic [JW-1:0] j);
        return {s, j};
    endfunction

endpackage

// File: rtl/acs_322_if.sv
// Branch-metric input and decision/metric output bundle of the ACS stage.
interface acs_322_if
    import vit322_pkg::*;
#(
    parameter int unsigned PMW = 6
);
    logic                             start;
    logic                             bm_valid;
    logic [N_HD-1:0][HDW-1:0]         hd;
    logic [DECW-1:0]                  dec;
    logic                             dec_valid;
    logic [SW-1:0]                    best_state;
    logic [N_STATES-1:0][PMW-1:0]     pm;

    modport master (
        output start, bm_valid, hd,
        input  dec, dec_valid, best_state, pm
    );

    modport slave (
        input  start, bm_valid, hd,
        output dec, dec_valid, best_state, pm
    );
endinterface

// File: rtl/acs_322_acs4.sv
// Four-way compare-select: minimum candidate and its branch index, lowest index wins ties.
module acs4_322 #(
    parameter int unsigned CW = 7
) (
    input  logic [CW-1:0] c0,
    input  logic [CW-1:0] c1,
    input  logic [CW-1:0] c2,
    input  logic [CW-1:0] c3,
    output logic [CW-1:0] min_c,
    output logic [1:0]    idx_c
);

    logic [CW-1:0] lo_v;
    logic [CW-1:0] hi_v;
    logic          lo_i;
    logic          hi_i;

    // The higher-index side only wins on a strict less-than.
    always_comb begin
        lo_v  = c0;
        lo_i  = 1'b0;
        hi_v  = c2;
        hi_i  = 1'b0;
        min_c = '0;
        idx_c = '0;
        if (c1 < c0) begin
            lo_v = c1;
            lo_i = 1'b1;
        end
        if (c3 < c2) begin
            hi_v = c3;
            hi_i = 1'b1;
        end
        if (hi_v < lo_v) begin
            min_c = hi_v;
            idx_c = {1'b1, hi_i};
        end else begin
            min_c = lo_v;
            idx_c = {1'b0, lo_i};
        end
    end

endmodule

// File: rtl/acs_322.sv
// Add-compare-select stage of the (3,2,2) backward-label Viterbi decoder.
module acs_322
    import vit322_pkg::*;
#(
    parameter int unsigned PMW = 6
) (
    input logic      clock,
    input logic      reset,
    acs_322_if.slave bus
);

    localparam int unsigned CW     = PMW + 1;
    localparam int unsigned PM_RST = 2 ** (PMW - 2);

    acs_state_e                   state;
    logic [N_STATES-1:0][PMW-1:0] pm_q;
    logic [DECW-1:0]              dec_q;
    logic [SW-1:0]                best_q;
    logic                         dv_q;

    logic [CW-1:0]                cand [N_STATES][N_BR];
    logic [CW-1:0]                win  [N_STATES];
    logic [JW-1:0]                sel  [N_STATES];
    logic [N_STATES-1:0][PMW-1:0] pm_nxt;
    logic [DECW-1:0]              dec_nxt;
    logic [SW-1:0]                best_nxt;
    logic                         norm;
    logic                         ovf;

    logic [CW-1:0]                l1_v [4];
    logic [SW-1:0]                l1_i [4];
    logic [CW-1:0]                l2_v [2];
    logic [SW-1:0]                l2_i [2];

    // Candidate adders, one extra bit so a carry out is visible.
    always_comb begin
        for (int s = 0; s < int'(N_STATES); s++) begin
            for (int j = 0; j < int'(N_BR); j++) begin
                cand[s][j] = CW'(pm_q[pred(SW'(s), JW'(j))])
                           + CW'(bus.hd[hd_idx(SW'(s), JW'(j))]);
            end
        end
    end

    for (genvar g = 0; g < int'(N_STATES); g++) begin : g_acs
        acs4_322 #(.CW(CW)) u_acs4 (
            .c0    (cand[g][0]),
            .c1    (cand[g][1]),
            .c2    (cand[g][2]),
            .c3    (cand[g][3]),
            .min_c (win[g]),
            .idx_c (sel[g])
        );
    end

    // Common MSB clear keeps the metrics bounded without changing their order.
    always_comb begin
        norm    = 1'b1;
        ovf     = 1'b0;
        pm_nxt  = '0;
        dec_nxt = '0;
        for (int s = 0; s < int'(N_STATES); s++) begin
            norm = norm & win[s][PMW-1];
            ovf  = ovf | win[s][PMW];
        end
        for (int s = 0; s < int'(N_STATES); s++) begin
            pm_nxt[s] = win[s][PMW-1:0];
            if (norm) begin
                pm_nxt[s][PMW-1] = 1'b0;
            end
            dec_nxt[2*s +: 2] = sel[s];
        end
    end

    // Best-state tree; at each node the higher index needs a strictly smaller metric.
    always_comb begin
        l1_v     = '{default: '0};
        l1_i     = '{default: '0};
        l2_v     = '{default: '0};
        l2_i     = '{default: '0};
        best_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if (win[2*i+1] < win[2*i]) begin
                l1_v[i] = win[2*i+1];
                l1_i[i] = SW'(2*i+1);
            end else begin
                l1_v[i] = win[2*i];
                l1_i[i] = SW'(2*i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (l1_v[2*i+1] < l1_v[2*i]) begin
                l2_v[i] = l1_v[2*i+1];
                l2_i[i] = l1_i[2*i+1];
            end else begin
                l2_v[i] = l1_v[2*i];
                l2_i[i] = l1_i[2*i];
            end
        end
        best_nxt = (l2_v[1] < l2_v[0]) ? l2_i[1] : l2_i[0];
    end

    // Control FSM and result registers; start overrides any step in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_INIT;
            dv_q   <= 1'b0;
            dec_q  <= '0;
            best_q <= '0;
            for (int s = 0; s < int'(N_STATES); s++) begin
                pm_q[s] <= (s == 0) ? '0 : PMW'(PM_RST);
            end
        end else begin
            dv_q <= 1'b0;
            if (bus.start) begin
                state  <= ST_INIT;
                dec_q  <= '0;
                best_q <= '0;
                for (int s = 0; s < int'(N_STATES); s++) begin
                    pm_q[s] <= (s == 0) ? '0 : PMW'(PM_RST);
                end
            end else if (bus.bm_valid) begin
                if (state == ST_INIT) begin
                    state <= ST_RUN;
                end
                pm_q   <= pm_nxt;
                dec_q  <= dec_nxt;
                best_q <= best_nxt;
                dv_q   <= 1'b1;
                assert (!ovf);
            end
        end
    end

    assign bus.pm         = pm_q;
    assign bus.dec        = dec_q;
    assign bus.best_state = best_q;
    assign bus.dec_valid  = dv_q;

endmodule

// File: tb/tb_acs_322.sv
// Scoreboard bench for acs_322 against a behavioural add-compare-select model.
module tb_acs_322;

    localparam int PMW  = 6;
    localparam int INIT = 1 << (PMW - 2);
    localparam int HALF = 1 << (PMW - 1);

    typedef struct {
        logic [15:0]         dec;
        logic [2:0]          best;
        logic [7:0][PMW-1:0] pm;
        bit                  zero;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    acs_322_if #(.PMW(PMW)) bus ();

    acs_322 #(.PMW(PMW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    int   m[8];
    logic [2:0] enc;
    bit   clean;
    logic [7:0][PMW-1:0] rst_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0][PMW-1:0] model_vec();
        logic [7:0][PMW-1:0] v;
        for (int s = 0; s < 8; s++) v[s] = PMW'(m[s]);
        return v;
    endfunction

    task automatic model_init();
        for (int s = 0; s < 8; s++) m[s] = (s == 0) ? 0 : INIT;
    endtask

    // Reference step: min over predecessors {s&1, j}, lowest j on ties, then common normalisation.
    task automatic model_step(input logic [31:0][1:0] h);
        exp_t e;
        int   nm[8];
        int   bv;
        bit   all_hi;
        e.dec  = '0;
        e.best = '0;
        e.zero = clean;
        all_hi = 1'b1;
        for (int s = 0; s < 8; s++) begin
            nm[s] = 1 << 30;
            for (int j = 0; j < 4; j++) begin
                int c;
                c = m[(s % 2) * 4 + j] + int'(h[4*s+j]);
                if (c < nm[s]) begin
                    nm[s] = c;
                    e.dec[2*s +: 2] = 2'(j);
                end
            end
            if (nm[s] < HALF) all_hi = 1'b0;
        end
        bv = 1 << 30;
        for (int s = 0; s < 8; s++) begin
            if (all_hi) nm[s] = nm[s] - HALF;
            if (nm[s] < bv) begin
                bv     = nm[s];
                e.best = 3'(s);
            end
            m[s] = nm[s];
        end
        e.pm = model_vec();
        sb.push_back(e);
    endtask

    task automatic drive(input logic rv, input logic st, input logic bv, input logic [31:0][1:0] h);
        @(negedge clock);
        reset        = rv;
        bus.start    = st;
        bus.bm_valid = bv;
        bus.hd       = h;
        if (!rv || st) model_init();
        else if (bv) model_step(h);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0][1:0] rand_hd();
        logic [31:0][1:0] h;
        for (int k = 0; k < 32; k++) h[k] = 2'($urandom_range(0, 3));
        return h;
    endfunction

    function automatic logic [31:0][1:0] fill_hd(input int v);
        logic [31:0][1:0] h;
        for (int k = 0; k < 32; k++) h[k] = 2'(v);
        return h;
    endfunction

    function automatic logic [2:0] label(input logic [2:0] p, input logic [1:0] u);
        return {u[0] ^ u[1] ^ p[2], u[1] ^ p[1] ^ p[0], u[0] ^ p[0] ^ p[2]};
    endfunction

    // Hamming distance of the received triple to every branch label of the trellis.
    function automatic logic [31:0][1:0] rx_hd(input logic [2:0] rx);
        logic [31:0][1:0] h;
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < 4; j++) begin
                logic [2:0] p;
                logic [2:0] sv;
                sv = 3'(s);
                p  = {sv[0], 2'(j)};
                h[4*s+j] = 2'($countones(label(p, sv[2:1]) ^ rx));
            end
        end
        return h;
    endfunction

    // Monitor: every dec_valid pulse must match the oldest expected step.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.dec_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_dec_valid", 64'(bus.dec_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_dec", 64'(bus.dec), 64'(e.dec));
                    check("sb_best", 64'(bus.best_state), 64'(e.best));
                    check("sb_pm", 64'(bus.pm), 64'(e.pm));
                    if (e.zero) check("clean_best_pm_zero", 64'(bus.pm[bus.best_state]), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0][1:0] h;
        logic [7:0][PMW-1:0] v;
        for (int s = 0; s < 8; s++) rst_v[s] = (s == 0) ? '0 : PMW'(INIT);
        bus.start    = 1'b0;
        bus.bm_valid = 1'b0;
        bus.hd       = '0;
        enc          = '0;
        clean        = 1'b0;
        model_init();

        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        check("reset_pm", 64'(bus.pm), 64'(rst_v));
        check("reset_dec", 64'(bus.dec), 64'd0);
        check("reset_dv", 64'(bus.dec_valid), 64'd0);
        check("reset_best", 64'(bus.best_state), 64'd0);

        // Single step from reset with the all-zero received pattern on state 0.
        h = fill_hd(2);
        h[0] = 2'd0;
        drive(1'b1, 1'b0, 1'b1, h);
        check("t1_dv", 64'(bus.dec_valid), 64'd1);
        check("t1_pm0", 64'(bus.pm[0]), 64'd0);
        check("t1_dec0", 64'(bus.dec[1:0]), 64'd0);
        check("t1_best", 64'(bus.best_state), 64'd0);
        drive(1'b1, 1'b0, 1'b0, rand_hd());
        check("t1_dv_pulse", 64'(bus.dec_valid), 64'd0);

        // Four equal candidates into state 3.
        drive(1'b0, 1'b0, 1'b0, '0);
        h = fill_hd(3);
        for (int k = 12; k < 16; k++) h[k] = 2'd1;
        drive(1'b1, 1'b0, 1'b1, h);
        check("t2_tie_dec3", 64'(bus.dec[7:6]), 64'd0);
        check("t2_tie_pm3", 64'(bus.pm[3]), 64'(INIT + 1));

        // Climb with unit metrics until the common MSB clears.
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int n = 0; n < 2 * HALF; n++) begin
            drive(1'b1, 1'b0, 1'b1, fill_hd(1));
            if (n == HALF - 2) begin
                for (int s = 0; s < 8; s++) v[s] = PMW'(HALF - 1);
                check("t3_pre_norm", 64'(bus.pm), 64'(v));
            end
            if (n == HALF - 1) check("t3_post_norm", 64'(bus.pm), 64'd0);
        end

        // start together with bm_valid discards the step.
        for (int n = 0; n < 5; n++) drive(1'b1, 1'b0, 1'b1, rand_hd());
        drive(1'b1, 1'b1, 1'b1, rand_hd());
        check("t4_pm", 64'(bus.pm), 64'(rst_v));
        check("t4_dv", 64'(bus.dec_valid), 64'd0);
        drive(1'b1, 1'b0, 1'b1, rand_hd());
        check("t4_next_dv", 64'(bus.dec_valid), 64'd1);

        // Reset mid-stream.
        for (int n = 0; n < 5; n++) drive(1'b1, 1'b0, 1'b1, rand_hd());
        drive(1'b0, 1'b0, 1'b1, rand_hd());
        check("t5_pm", 64'(bus.pm), 64'(rst_v));
        check("t5_dec", 64'(bus.dec), 64'd0);
        check("t5_dv", 64'(bus.dec_valid), 64'd0);
        check("t5_best", 64'(bus.best_state), 64'd0);

        // Encoded random data: clean first, then channel errors with gaps and restarts.
        drive(1'b1, 1'b1, 1'b0, '0);
        enc   = '0;
        clean = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            logic [1:0] u;
            logic [2:0] err;
            if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b0, 1'b0, rand_hd());
            if (n > 4000 && $urandom_range(0, 499) == 0) begin
                drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), rand_hd());
                enc   = '0;
                clean = 1'b1;
            end
            u   = 2'($urandom_range(0, 3));
            err = '0;
            if (n >= 4000) begin
                for (int b = 0; b < 3; b++) if ($urandom_range(0, 31) == 0) err[b] = 1'b1;
            end
            if (err != 3'b000) clean = 1'b0;
            h   = rx_hd(label(enc, u) ^ err);
            enc = {u, enc[2]};
            drive(1'b1, 1'b0, 1'b1, h);
        end
        clean = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0);
        repeat (4) @(negedge clock);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
